// File: rtl/drac_pkg.sv
// Shared definitions for the pipeline datapath blocks.
package drac_pkg;

  typedef enum logic {
    SB_REGISTERED  = 1'b0,
    SB_FALLTHROUGH = 1'b1
  } stage_buf_mode_t;

endpackage

// File: rtl/elastic_stage_buffer_fifo_ctrl.sv
// Pointer, occupancy and flag bookkeeping for a power-of-two circular queue.
module fifo_ctrl #(
  parameter int DEPTH = 2
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  output logic [$clog2(DEPTH)-1:0] rd_ptr,
  output logic [$clog2(DEPTH)-1:0] wr_ptr,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // Pointers wrap for free because DEPTH is a power of two.
  always_ff @(posedge clk_i) begin
    if (!rstn_i || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  a_no_push_full:  assert property (@(posedge clk_i) disable iff (!rstn_i) !(push && full));
  a_no_pop_empty:  assert property (@(posedge clk_i) disable iff (!rstn_i) !(pop && empty));
  a_count_bound:   assert property (@(posedge clk_i) disable iff (!rstn_i) count <= CW'(DEPTH));
  a_flags_disjoint: assert property (@(posedge clk_i) disable iff (!rstn_i) !(full && empty));

endmodule

// File: rtl/elastic_stage_buffer.sv
// Elastic pipeline stage: DEPTH-entry FIFO with valid/ready on both sides,
// optional empty-buffer bypass and whole-buffer flush.
module elastic_stage_buffer
  import drac_pkg::*;
#(
  parameter int              DATA_WIDTH  = 64,
  parameter int              DEPTH       = 2,
  parameter stage_buf_mode_t FALLTHROUGH = SB_REGISTERED
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic                    flush_i,
  input  logic                    valid_i,
  input  logic [DATA_WIDTH-1:0]   data_i,
  output logic                    ready_o,
  output logic                    valid_o,
  output logic [DATA_WIDTH-1:0]   data_o,
  input  logic                    ready_i,
  output logic [$clog2(DEPTH):0]  count_o,
  output logic                    full_o,
  output logic                    empty_o
);

  // Handshake: a transfer happens on a side when valid and ready are both high
  // at a rising edge and flush_i is low; ready_o never looks at ready_i.
  localparam int PW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         wr_ptr;
  logic                  push;
  logic                  pop;
  logic                  bypass;
  logic                  through;
  logic                  ctrl_push;
  logic                  ctrl_pop;

  assign ready_o = !full_o;
  assign push    = valid_i && ready_o && !flush_i;
  assign bypass  = (FALLTHROUGH == SB_FALLTHROUGH) && empty_o && valid_i && !flush_i;
  assign valid_o = !flush_i && (!empty_o || bypass);
  assign data_o  = bypass ? data_i : mem[rd_ptr];
  assign pop     = valid_o && ready_i && !flush_i;

  // A bypassed payload consumed in the same cycle never touches storage.
  assign through   = bypass && ready_i;
  assign ctrl_push = push && !through;
  assign ctrl_pop  = pop && !through;

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (ctrl_push) begin
      mem[wr_ptr] <= data_i;
    end
  end

  fifo_ctrl #(
    .DEPTH(DEPTH)
  ) u_ctrl (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .push   (ctrl_push),
    .pop    (ctrl_pop),
    .flush  (flush_i),
    .rd_ptr (rd_ptr),
    .wr_ptr (wr_ptr),
    .count  (count_o),
    .full   (full_o),
    .empty  (empty_o)
  );

endmodule

// File: tb/tb_elastic_stage_buffer.sv
// Bench for elastic_stage_buffer: one registered and one fall-through instance,
// each checked every cycle against a queue model of the FIFO contract.
module tb_elastic_stage_buffer;
  import drac_pkg::*;

  localparam int W     = 8;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic clk;
  logic rstn;

  logic          r_flush, r_valid, r_ready_i, r_ready_o, r_valid_o, r_full, r_empty;
  logic [W-1:0]  r_data, r_data_o;
  logic [CW-1:0] r_count;

  logic          f_flush, f_valid, f_ready_i, f_ready_o, f_valid_o, f_full, f_empty;
  logic [W-1:0]  f_data, f_data_o;
  logic [CW-1:0] f_count;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] ft_q[$];
  logic [W-1:0] got_q[$];
  logic         last_r_push;

  int n_cmp = 0;
  int n_bad = 0;

  elastic_stage_buffer #(
    .DATA_WIDTH(W), .DEPTH(DEPTH), .FALLTHROUGH(SB_REGISTERED)
  ) u_reg (
    .clk_i(clk), .rstn_i(rstn), .flush_i(r_flush), .valid_i(r_valid), .data_i(r_data),
    .ready_o(r_ready_o), .valid_o(r_valid_o), .data_o(r_data_o), .ready_i(r_ready_i),
    .count_o(r_count), .full_o(r_full), .empty_o(r_empty)
  );

  elastic_stage_buffer #(
    .DATA_WIDTH(W), .DEPTH(DEPTH), .FALLTHROUGH(SB_FALLTHROUGH)
  ) u_ft (
    .clk_i(clk), .rstn_i(rstn), .flush_i(f_flush), .valid_i(f_valid), .data_i(f_data),
    .ready_o(f_ready_o), .valid_o(f_valid_o), .data_o(f_data_o), .ready_i(f_ready_i),
    .count_o(f_count), .full_o(f_full), .empty_o(f_empty)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: check outputs of both instances against the model using the
  // inputs currently applied, then advance the model across the rising edge.
  task automatic tick();
    logic er_valid, ef_valid, ef_bypass, ef_through;
    logic r_push, r_pop, f_push, f_pop;
    logic [W-1:0] ef_data;
    #1;
    er_valid = !r_flush && (exp_q.size() != 0);
    chk("r_ready", r_ready_o, exp_q.size() < DEPTH);
    chk("r_count", r_count, exp_q.size());
    chk("r_full", r_full, exp_q.size() == DEPTH);
    chk("r_empty", r_empty, exp_q.size() == 0);
    chk("r_valid", r_valid_o, er_valid);
    if (er_valid) chk("r_data", r_data_o, exp_q[0]);

    ef_bypass = (ft_q.size() == 0) && f_valid && !f_flush;
    ef_valid  = !f_flush && (ft_q.size() != 0 || ef_bypass);
    ef_data   = (ft_q.size() != 0) ? ft_q[0] : f_data;
    chk("f_ready", f_ready_o, ft_q.size() < DEPTH);
    chk("f_count", f_count, ft_q.size());
    chk("f_full", f_full, ft_q.size() == DEPTH);
    chk("f_empty", f_empty, ft_q.size() == 0);
    chk("f_valid", f_valid_o, ef_valid);
    if (ef_valid) chk("f_data", f_data_o, ef_data);

    r_push     = r_valid && (exp_q.size() < DEPTH) && !r_flush;
    r_pop      = er_valid && r_ready_i;
    f_push     = f_valid && (ft_q.size() < DEPTH) && !f_flush;
    f_pop      = ef_valid && f_ready_i;
    ef_through = ef_bypass && f_ready_i;

    @(posedge clk);
    if (!rstn) begin
      exp_q.delete();
      ft_q.delete();
    end else begin
      if (r_flush) exp_q.delete();
      else begin
        if (r_pop)  got_q.push_back(exp_q.pop_front());
        if (r_push) exp_q.push_back(r_data);
      end
      if (f_flush) ft_q.delete();
      else if (!ef_through) begin
        if (f_pop)  void'(ft_q.pop_front());
        if (f_push) ft_q.push_back(f_data);
      end
    end
    last_r_push = r_push && rstn;
    @(negedge clk);
  endtask

  task automatic drive_r(input logic v, input logic [W-1:0] d, input logic rdy, input logic fl);
    r_valid = v; r_data = d; r_ready_i = rdy; r_flush = fl;
  endtask

  task automatic drive_f(input logic v, input logic [W-1:0] d, input logic rdy, input logic fl);
    f_valid = v; f_data = d; f_ready_i = rdy; f_flush = fl;
  endtask

  initial begin
    int k;
    logic tgl;
    rstn = 1'b0;
    drive_r(1'b0, '0, 1'b0, 1'b0);
    drive_f(1'b0, '0, 1'b0, 1'b0);
    last_r_push = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    tick();

    // Reset mid-stream
    drive_r(1'b1, 8'h11, 1'b0, 1'b0); tick();
    drive_r(1'b1, 8'h12, 1'b0, 1'b0); tick();
    drive_r(1'b0, 8'h00, 1'b0, 1'b0);
    rstn = 1'b0; tick();
    rstn = 1'b1;
    #1;
    chk("t1_valid", r_valid_o, 1'b0);
    chk("t1_count", r_count, 0);
    chk("t1_ready", r_ready_o, 1'b1);
    chk("t1_empty", r_empty, 1'b1);
    tick();

    // Fill to full with the consumer stalled
    for (int i = 0; i < 4; i++) begin
      drive_r(1'b1, 8'hA0 + 8'(i), 1'b0, 1'b0);
      tick();
    end
    #1;
    chk("t2_full", r_full, 1'b1);
    chk("t2_ready", r_ready_o, 1'b0);
    drive_r(1'b1, 8'hA4, 1'b0, 1'b0); tick();
    #1;
    chk("t2_count", r_count, 4);
    chk("t2_head", r_data_o, 8'hA0);
    drive_r(1'b0, '0, 1'b1, 1'b0);
    repeat (4) tick();

    // Wrap-around with a toggling consumer
    got_q.delete();
    k = 0;
    tgl = 1'b1;
    for (int c = 0; c < 100 && k < 10; c++) begin
      drive_r(1'b1, 8'(k), tgl, 1'b0);
      tgl = !tgl;
      tick();
      if (last_r_push) k++;
    end
    chk("t3_pushes", k, 10);
    drive_r(1'b0, '0, 1'b1, 1'b0);
    repeat (6) tick();
    chk("t3_recv_cnt", got_q.size(), 10);
    for (int i = 0; i < 10 && i < got_q.size(); i++) chk("t3_order", got_q[i], 8'(i));

    // Simultaneous push and pop at count 2
    drive_r(1'b1, 8'hB0, 1'b0, 1'b0); tick();
    drive_r(1'b1, 8'hB1, 1'b0, 1'b0); tick();
    drive_r(1'b1, 8'hB2, 1'b1, 1'b0); tick();
    #1;
    chk("t4_count", r_count, 2);
    chk("t4_head", r_data_o, 8'hB1);
    drive_r(1'b0, '0, 1'b1, 1'b0);
    repeat (3) tick();

    // Flush beats a concurrent push and pop
    for (int i = 0; i < 3; i++) begin
      drive_r(1'b1, 8'hC0 + 8'(i), 1'b0, 1'b0);
      tick();
    end
    drive_r(1'b1, 8'hC3, 1'b1, 1'b1);
    #1;
    chk("t5_valid_in_flush", r_valid_o, 1'b0);
    tick();
    drive_r(1'b0, '0, 1'b1, 1'b0);
    #1;
    chk("t5_count", r_count, 0);
    chk("t5_valid_after", r_valid_o, 1'b0);
    repeat (2) tick();

    // Fall-through on an empty buffer
    drive_f(1'b1, 8'h55, 1'b1, 1'b0);
    #1;
    chk("t6_bypass_valid", f_valid_o, 1'b1);
    chk("t6_bypass_data", f_data_o, 8'h55);
    chk("t6_bypass_count", f_count, 0);
    tick();
    #1;
    chk("t6_through_count", f_count, 0);
    drive_f(1'b1, 8'h55, 1'b0, 1'b0); tick();
    drive_f(1'b0, 8'h00, 1'b0, 1'b0);
    #1;
    chk("t6_store_count", f_count, 1);
    chk("t6_store_data", f_data_o, 8'h55);
    drive_f(1'b0, '0, 1'b1, 1'b0);
    repeat (2) tick();

    // Random traffic on both instances
    for (int c = 0; c < 600; c++) begin
      drive_r($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 2) != 0,
              $urandom_range(0, 24) == 0);
      drive_f($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 2) != 0,
              $urandom_range(0, 24) == 0);
      rstn = ($urandom_range(0, 99) != 0);
      tick();
    end
    rstn = 1'b1;
    drive_r(1'b0, '0, 1'b1, 1'b0);
    drive_f(1'b0, '0, 1'b1, 1'b0);
    repeat (6) tick();
    #1;
    chk("end_r_empty", r_empty, 1'b1);
    chk("end_f_empty", f_empty, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
